// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access unit.
package mem_pkg;

  localparam int unsigned BE_W     = 4;
  localparam int unsigned FUNCT3_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

  // Misaligned halves/words and unused funct3 codes never reach memory.
  function automatic logic is_bad_access(input logic [FUNCT3_W-1:0] funct3,
                                         input logic [1:0]          offset);
    case (funct3)
      F3_B, F3_BU: is_bad_access = 1'b0;
      F3_H, F3_HU: is_bad_access = offset[0];
      F3_W:        is_bad_access = (offset != 2'b00);
      default:     is_bad_access = 1'b1;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_enable(input logic [FUNCT3_W-1:0] funct3,
                                                  input logic [1:0]          offset);
    case (funct3[1:0])
      2'b00:   byte_enable = BE_W'(1) << offset;
      2'b01:   byte_enable = BE_W'(3) << offset;
      default: byte_enable = {BE_W{1'b1}};
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            offset,
  input  logic [FUNCT3_W-1:0]   funct3,
  output logic [DATA_WIDTH-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {offset, 3'b000});
    half_sel = 16'(word >> {offset[1], 4'b0000});
    data_c   = word;
    case (funct3)
      F3_B:    data_c = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_H:    data_c = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_BU:   data_c = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_HU:   data_c = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: captures a load/store from execute, runs the memory
// handshake and returns the extended load result or an alignment error pulse.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memWriteE_i,
  input  logic                  memReadE_i,
  input  logic [FUNCT3_W-1:0]   funct3E_i,
  input  logic [DATA_WIDTH-1:0] ALUresultE_i,
  input  logic [DATA_WIDTH-1:0] RD2E_i,
  output logic                  stall_o,
  output logic                  memReq_o,
  output logic                  memWe_o,
  output logic [DATA_WIDTH-1:0] memAddr_o,
  output logic [DATA_WIDTH-1:0] memWdata_o,
  output logic [BE_W-1:0]       memBe_o,
  input  logic                  memGnt_i,
  input  logic                  memRvalid_i,
  input  logic [DATA_WIDTH-1:0] memRdata_i,
  output logic [DATA_WIDTH-1:0] readDataM_o,
  output logic                  readValidM_o,
  output logic                  misaligned_o
);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [FUNCT3_W-1:0]   funct3_q;
  logic                  store_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] wdata_lane;
  logic                  access;

  assign access      = memWriteE_i | memReadE_i;
  assign readDataM_o = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A store wins when both strobes are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (state == S_IDLE && access) begin
      addr_q   <= ALUresultE_i;
      wdata_q  <= RD2E_i;
      funct3_q <= funct3E_i;
      store_q  <= memWriteE_i;
      err_q    <= is_bad_access(funct3E_i, ALUresultE_i[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              rdata_q <= '0;
    else if (state == S_WAIT && memRvalid_i) rdata_q <= load_data;
  end

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .word   (memRdata_i),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .data_c (load_data)
  );

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   wdata_lane = {(DATA_WIDTH/8){wdata_q[7:0]}};
      2'b01:   wdata_lane = {(DATA_WIDTH/16){wdata_q[15:0]}};
      default: wdata_lane = wdata_q;
    endcase
  end

  // Next state and state-decoded outputs; request outputs are quiet outside REQ.
  always_comb begin
    state_nxt    = state;
    stall_o      = 1'b0;
    memReq_o     = 1'b0;
    memWe_o      = 1'b0;
    memAddr_o    = '0;
    memWdata_o   = '0;
    memBe_o      = '0;
    readValidM_o = 1'b0;
    misaligned_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          stall_o   = 1'b1;
          state_nxt = is_bad_access(funct3E_i, ALUresultE_i[1:0]) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        stall_o    = 1'b1;
        memReq_o   = 1'b1;
        memWe_o    = store_q;
        memAddr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
        memWdata_o = wdata_lane;
        memBe_o    = byte_enable(funct3_q, addr_q[1:0]);
        if (memGnt_i) state_nxt = store_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (memRvalid_i) state_nxt = S_DONE;
      end
      S_DONE: begin
        readValidM_o = ~store_q & ~err_q;
        misaligned_o = err_q;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: random loads/stores against a byte-lane
// reference model, a responsive memory with random grant/read latency, and resets.
module tb_mem_access_unit;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          memWriteE_i, memReadE_i;
  logic [2:0]    funct3E_i;
  logic [DW-1:0] ALUresultE_i, RD2E_i;
  logic          stall_o, memReq_o, memWe_o;
  logic [DW-1:0] memAddr_o, memWdata_o;
  logic [3:0]    memBe_o;
  logic          memGnt_i, memRvalid_i;
  logic [DW-1:0] memRdata_i, readDataM_o;
  logic          readValidM_o, misaligned_o;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .memWriteE_i(memWriteE_i), .memReadE_i(memReadE_i), .funct3E_i(funct3E_i),
    .ALUresultE_i(ALUresultE_i), .RD2E_i(RD2E_i), .stall_o(stall_o),
    .memReq_o(memReq_o), .memWe_o(memWe_o), .memAddr_o(memAddr_o),
    .memWdata_o(memWdata_o), .memBe_o(memBe_o), .memGnt_i(memGnt_i),
    .memRvalid_i(memRvalid_i), .memRdata_i(memRdata_i), .readDataM_o(readDataM_o),
    .readValidM_o(readValidM_o), .misaligned_o(misaligned_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } cpl_t;

  req_t req_q[$];
  cpl_t cpl_q[$];
  int   lat_q[$];
  int   total = 0;
  int   bad = 0;

  // memory responder knobs, set by the driver before each access
  int          gnt_delay = 0;
  int          rv_delay = 0;
  logic [31:0] load_word = '0;
  bit          noise = 1'b0;
  bit          late_rv = 1'b0;
  logic [31:0] model_rd = '0;

  int          req_cnt = 0;
  int          wait_cnt = 0;
  bit          outstanding = 1'b0;

  int          run = 0;
  logic [31:0] hold = '0;
  bit          prev_rv = 1'b0;
  bit          prev_mis = 1'b0;
  cpl_t        cpl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_err(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = size_of(f3);
    if (sz == 0) return 1'b1;
    return (int'(addr[1:0]) % sz) != 0;
  endfunction

  // lane i of the bus carries data byte (i mod size); enables cover the accessed bytes
  function automatic req_t model_store(input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] data);
    req_t        r;
    int unsigned sz = size_of(f3);
    int unsigned off = int'(addr[1:0]);
    r.addr  = addr & 32'hFFFF_FFFC;
    r.we    = 1'b1;
    r.be    = '0;
    r.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + sz) r.be[i] = 1'b1;
      r.wdata[8*i +: 8] = data[8*(i % sz) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] v = word >> (8 * int'(addr[1:0]));
    case (size_of(f3))
      1: begin
        v = v & 32'h0000_00FF;
        if (!f3[2] && v >= 32'h80) v = v - 32'h100;
      end
      2: begin
        v = v & 32'h0000_FFFF;
        if (!f3[2] && v >= 32'h8000) v = v - 32'h1_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_stall"}, 32'(stall_o), 0);
    check({tag, "_req"}, 32'(memReq_o), 0);
    check({tag, "_we"}, 32'(memWe_o), 0);
    check({tag, "_addr"}, memAddr_o, 0);
    check({tag, "_wdata"}, memWdata_o, 0);
    check({tag, "_be"}, 32'(memBe_o), 0);
    check({tag, "_rdata"}, readDataM_o, 0);
    check({tag, "_rvalid"}, 32'(readValidM_o), 0);
    check({tag, "_misaligned"}, 32'(misaligned_o), 0);
  endtask

  task automatic drop_inputs();
    memWriteE_i  = 1'b0;
    memReadE_i   = 1'b0;
    funct3E_i    = 3'($urandom);
    ALUresultE_i = $urandom;
    RD2E_i       = $urandom;
  endtask

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic issue(input bit wr, input bit rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int g, input int r, input logic [31:0] word);
    int n = 0;
    if (model_err(f3, addr)) begin
      cpl_q.push_back('{1'b1, model_rd});
      lat_q.push_back(1);
    end else if (wr) begin
      req_q.push_back(model_store(f3, addr, data));
      lat_q.push_back(2 + g);
    end else begin
      req_q.push_back('{addr & 32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0});
      model_rd = model_load(f3, addr, word);
      cpl_q.push_back('{1'b0, model_rd});
      lat_q.push_back(3 + g + r);
    end
    gnt_delay    = g;
    rv_delay     = r;
    load_word    = word;
    memWriteE_i  = wr;
    memReadE_i   = rd;
    funct3E_i    = f3;
    ALUresultE_i = addr;
    RD2E_i       = data;
    do begin
      @(negedge clk); #1;
      n++;
    end while (stall_o && n < 64);
    if (stall_o) check("stall_drop", 32'(stall_o), 0);
    @(posedge clk); #1;
    drop_inputs();
  endtask

  // Memory model: grant after gnt_delay request cycles, read data rv_delay cycles later.
  initial begin
    memGnt_i = 1'b0; memRvalid_i = 1'b0; memRdata_i = '0;
    forever begin
      @(negedge clk);
      memGnt_i   = 1'b0;
      memRdata_i = $urandom;
      if (!rst_n) begin
        req_cnt = 0; wait_cnt = 0; outstanding = 1'b0;
        memRvalid_i = late_rv;
      end else if (outstanding) begin
        memRvalid_i = 1'b0;
        if (wait_cnt == rv_delay) begin
          memRvalid_i = 1'b1;
          memRdata_i  = load_word;
          outstanding = 1'b0;
        end else wait_cnt++;
      end else begin
        memRvalid_i = noise ? 1'($urandom_range(0, 1)) : late_rv;
        if (memReq_o) begin
          if (req_cnt == gnt_delay) begin
            memGnt_i = 1'b1;
            req_cnt  = 0;
            if (!memWe_o) begin outstanding = 1'b1; wait_cnt = 0; end
          end else req_cnt++;
        end
      end
    end
  end

  // Monitor: request stability/contents, completion pulses, held read data, stall length.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        run = 0; hold = '0; prev_rv = 1'b0; prev_mis = 1'b0;
      end else begin
        if (memReq_o) begin
          check("req_pending", 32'(req_q.size() != 0), 1);
          if (req_q.size() != 0) begin
            check("req_addr", memAddr_o, req_q[0].addr);
            check("req_we", 32'(memWe_o), 32'(req_q[0].we));
            if (req_q[0].we) begin
              check("req_be", 32'(memBe_o), 32'(req_q[0].be));
              check("req_wdata", memWdata_o, req_q[0].wdata);
            end
            if (memGnt_i) void'(req_q.pop_front());
          end
        end
        if (readValidM_o || misaligned_o) begin
          check("pulse_width", 32'((prev_rv && readValidM_o) || (prev_mis && misaligned_o)), 0);
          check("cpl_pending", 32'(cpl_q.size() != 0), 1);
          if (cpl_q.size() != 0) begin
            cpl = cpl_q.pop_front();
            check("cpl_rvalid", 32'(readValidM_o), 32'(!cpl.err));
            check("cpl_misaligned", 32'(misaligned_o), 32'(cpl.err));
            hold = cpl.data;
          end
        end
        check("read_data", readDataM_o, hold);
        prev_rv  = readValidM_o;
        prev_mis = misaligned_o;
        if (stall_o) run++;
        else if (run > 0) begin
          check("lat_pending", 32'(lat_q.size() != 0), 1);
          if (lat_q.size() != 0) check("stall_cycles", 32'(run), 32'(lat_q.pop_front()));
          run = 0;
        end
      end
    end
  end

  logic [2:0] codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    int unsigned sz;
    int          k;
    rst_n = 1'b0;
    drop_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1, 0, 3'b010, 32'h104, 32'hDEAD_BEEF, 2, 0, 32'h0);
    issue(0, 1, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80FF_0000);
    issue(0, 1, 3'b101, 32'h202, 32'h0, 1, 2, 32'h8001_1234);
    issue(1, 0, 3'b000, 32'h1, 32'h0000_00AB, 0, 0, 32'h0);
    issue(0, 1, 3'b010, 32'h106, 32'h0, 0, 0, 32'h1111_1111);
    issue(1, 1, 3'b001, 32'h2, 32'h1234_5678, 0, 0, 32'hFFFF_FFFF);
    issue(0, 1, 3'b011, 32'h0, 32'h0, 0, 0, 32'h0);
    issue(1, 0, 3'b110, 32'h8, 32'h5555_5555, 0, 0, 32'h0);
    issue(0, 1, 3'b100, 32'h7, 32'h0, 3, 1, 32'hF0E0_D0C0);
    issue(0, 1, 3'b001, 32'h2, 32'h0, 0, 0, 32'h8000_7FFF);

    // reset while waiting for read data; a late read-valid must be ignored
    req_q.push_back('{32'h40, 1'b0, 4'h0, 32'h0});
    gnt_delay = 0; rv_delay = 50; load_word = $urandom;
    memReadE_i = 1'b1; funct3E_i = 3'b010; ALUresultE_i = 32'h40;
    repeat (3) begin @(posedge clk); #1; end
    check("wait_stall", 32'(stall_o), 1);
    rst_n = 1'b0;
    drop_inputs();
    late_rv = 1'b1;
    #1;
    check_outputs_zero("midreset");
    req_q.delete(); cpl_q.delete(); lat_q.delete();
    model_rd = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      check("late_rv_stall", 32'(stall_o), 0);
      check("late_rv_req", 32'(memReq_o), 0);
      check("late_rv_valid", 32'(readValidM_o), 0);
    end
    late_rv = 1'b0;
    @(posedge clk); #1;

    noise = 1'b1;
    for (int i = 0; i < 200; i++) begin
      k  = $urandom_range(0, 2);
      f3 = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 4)] : 3'($urandom);
      addr = $urandom;
      sz = size_of(f3);
      if (sz > 1 && $urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
      issue(k != 1, k != 0, f3, addr, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    noise = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("req_q_left", 32'(req_q.size()), 0);
    check("cpl_q_left", 32'(cpl_q.size()), 0);
    check("lat_q_left", 32'(lat_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data, address and result width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 memWriteE_i  input  1  SHALL mean a store from the execute register.
REQ-005 memReadE_i  input  1  SHALL mean a load from the execute register (result-source = memory).
REQ-006 funct3E_i  input  3  SHALL give the access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUresultE_i  input  DATA_WIDTH  SHALL be the byte address.
REQ-008 RD2E_i  input  DATA_WIDTH  SHALL be the store data.
REQ-009 stall_o  output  1  SHALL hold the pipeline registers while high.
REQ-010 memReq_o, memWe_o  output  1 each  SHALL be the request and write-enable to data memory.
REQ-011 memAddr_o  output  DATA_WIDTH  SHALL be the word-aligned address, with bits [1:0] = 0.
REQ-012 memWdata_o  output  DATA_WIDTH and memBe_o  output  4  SHALL be the lane-placed store data and the byte enables.
REQ-013 memGnt_i, memRvalid_i  input  1 each and memRdata_i  input  DATA_WIDTH  SHALL be the memory grant, read-valid and read word.
REQ-014 readDataM_o  output  DATA_WIDTH, readValidM_o  output  1 and misaligned_o  output  1  SHALL be the extended load result, the load-complete pulse and the error pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, WAIT, DONE.
REQ-016 In IDLE, an access (memWriteE_i or memReadE_i) SHALL capture the address, data, funct3 and type into registers, and the next state SHALL be REQ, or DONE with an error.
REQ-017 When both memWriteE_i and memReadE_i are high, the access SHALL be treated as a store.
REQ-018 Misaligned accesses SHALL issue no memory request: H/HU with addr[0]=1, or W with addr[1:0]!=00.
REQ-019 Illegal funct3 values (011, 110, 111) SHALL also issue no memory request.
REQ-020 memReq_o SHALL be high only in REQ, with all request outputs driven from the captured registers and stable until memGnt_i.
REQ-021 In REQ, memGnt_i SHALL move the FSM to DONE for a store and to WAIT for a load; memRvalid_i in REQ SHALL be ignored.
REQ-022 In WAIT, memRvalid_i SHALL register the extended memRdata_i into readDataM_o and move the FSM to DONE.
REQ-023 In DONE, stall_o SHALL be low, and the FSM SHALL return to IDLE after exactly one cycle.
REQ-024 readValidM_o SHALL be high in DONE only after a load.
REQ-025 misaligned_o SHALL be high in DONE only after a REQ-018 or REQ-019 access.
REQ-026 stall_o SHALL equal (IDLE and access present) or REQ or WAIT.
REQ-027 Minimum latency SHALL be 3 cycles for a store with an immediate grant and 4 for a load, including DONE.
REQ-028 Byte enables SHALL be: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
REQ-029 Store data SHALL be lane-placed: B replicated 4x from [7:0]; H replicated 2x from [15:0]; W unchanged.
REQ-030 Loads SHALL select the byte or half at addr[1:0]; B and H SHALL be sign-extended, BU and HU zero-extended.
REQ-031 readDataM_o SHALL hold its value until the next load completes.
REQ-032 memRvalid_i in IDLE or DONE SHALL be ignored.

Reset
REQ-033 Asserting rst_n low SHALL immediately force IDLE, clear the captured registers, and zero every output.
REQ-034 Reset mid-operation SHALL abandon any outstanding request, and a late memRvalid_i after reset SHALL be ignored.

Structure
REQ-035 A shared package mem_pkg SHALL hold the state enum, the funct3 size constants and the byte-enable width.
REQ-036 A combinational sub-module load_extend SHALL implement REQ-030, taking the word, addr[1:0] and funct3.

Verification
REQ-037 SW with addr 0x104, data 0xDEADBEEF, grant held off 2 cycles -> memReq_o high for 3 cycles, memAddr_o 0x104, memBe_o 1111, stall_o low only in DONE.
REQ-038 LB at addr 0x203 with memRdata_i 0x80FF_0000 -> readDataM_o 0xFFFFFF80 and readValidM_o pulses for 1 cycle.
REQ-039 LHU at addr 0x202 with memRdata_i 0x8001_1234 -> readDataM_o 0x00008001.
REQ-040 SB at addr 0x1 with data 0x000000AB -> memBe_o 0010 and memWdata_o 0xABABABAB.
REQ-041 LW at 0x106 -> no memReq_o, misaligned_o pulses 1 cycle, and readDataM_o is unchanged.
REQ-042 rst_n pulsed low while in WAIT, then memRvalid_i arrives -> state IDLE, outputs 0, and no readValidM_o.
